// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and default detector constants
package game_pkg;

    typedef enum logic [1:0] {
        NOT_TOUCHING = 2'd0,
        ARMING       = 2'd1,
        TOUCHING     = 2'd2,
        RELEASING    = 2'd3
    } rope_touch_state_t;

    // Also used by the ladder detector so both climbables feel the same.
    localparam int ROPE_MIN_OVERLAP     = 4;
    localparam int ROPE_DEBOUNCE_FRAMES = 2;

endpackage

// File: rtl/frame_overlap_counter.sv
// rtl/frame_overlap_counter.sv - per-frame overlap pixel counter with first-hit pulse and frame close latch
module frame_overlap_counter #(
    parameter int MIN_OVERLAP_PIXELS = 4,
    parameter int CNT_W              = 12
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             ov,
    output logic             hitPulse,
    output logic             frameHit,
    output logic [CNT_W-1:0] overlapCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   MIN_EXT = (CNT_W+1)'(MIN_OVERLAP_PIXELS);

    logic [CNT_W-1:0] cur_cnt;
    logic             seen_hit;

    // Valid only on the startOfFrame cycle, where it reflects the closing frame.
    assign frameHit = ({1'b0, cur_cnt} >= MIN_EXT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cur_cnt      <= '0;
            seen_hit     <= 1'b0;
            overlapCount <= '0;
            hitPulse     <= 1'b0;
        end else begin
            hitPulse <= ov & (startOfFrame | ~seen_hit);
            if (startOfFrame) begin
                // A pixel coincident with startOfFrame opens the new frame.
                overlapCount <= cur_cnt;
                cur_cnt      <= ov ? CNT_W'(1) : '0;
                seen_hit     <= ov;
            end else if (ov) begin
                seen_hit <= 1'b1;
                if (cur_cnt != CNT_MAX) begin
                    cur_cnt <= cur_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rope_collision_detector.sv
// rtl/rope_collision_detector.sv - player/rope overlap detector with frame-level debounce
module rope_collision_detector
    import game_pkg::*;
#(
    parameter int MIN_OVERLAP_PIXELS = ROPE_MIN_OVERLAP,
    parameter int DEBOUNCE_FRAMES    = ROPE_DEBOUNCE_FRAMES,
    parameter int CNT_W              = 12
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             enable,
    input  logic             ropeDR,
    input  logic             playerDR,
    output logic             hitPulse,
    output logic             touching,
    output logic             grabEvent,
    output logic             releaseEvent,
    output logic [CNT_W-1:0] overlapCount
);

    localparam logic [2:0] DEB = 3'(DEBOUNCE_FRAMES);

    logic              ov;
    logic              frame_hit;
    rope_touch_state_t state;
    rope_touch_state_t state_next;
    logic [2:0]        dcnt;
    logic [2:0]        dcnt_next;
    logic [2:0]        dcnt_inc;
    logic              grab_next;
    logic              release_next;

    assign ov       = enable & ropeDR & playerDR;
    assign dcnt_inc = dcnt + 3'd1;

    frame_overlap_counter #(
        .MIN_OVERLAP_PIXELS(MIN_OVERLAP_PIXELS),
        .CNT_W             (CNT_W)
    ) u_counter (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .ov          (ov),
        .hitPulse    (hitPulse),
        .frameHit    (frame_hit),
        .overlapCount(overlapCount)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= NOT_TOUCHING;
            dcnt         <= '0;
            touching     <= 1'b0;
            grabEvent    <= 1'b0;
            releaseEvent <= 1'b0;
        end else begin
            state        <= state_next;
            dcnt         <= dcnt_next;
            touching     <= (state_next == TOUCHING) || (state_next == RELEASING);
            grabEvent    <= grab_next;
            releaseEvent <= release_next;
        end
    end

    // Debounce moves only at frame boundaries; dcnt counts disagreeing frames.
    always_comb begin
        state_next   = state;
        dcnt_next    = dcnt;
        grab_next    = 1'b0;
        release_next = 1'b0;
        if (startOfFrame) begin
            case (state)
                NOT_TOUCHING: begin
                    if (frame_hit) begin
                        if (DEB == 3'd1) begin
                            state_next = TOUCHING;
                            grab_next  = 1'b1;
                        end else begin
                            state_next = ARMING;
                            dcnt_next  = 3'd1;
                        end
                    end
                end
                ARMING: begin
                    if (frame_hit) begin
                        if (dcnt_inc == DEB) begin
                            state_next = TOUCHING;
                            dcnt_next  = '0;
                            grab_next  = 1'b1;
                        end else begin
                            dcnt_next = dcnt_inc;
                        end
                    end else begin
                        state_next = NOT_TOUCHING;
                        dcnt_next  = '0;
                    end
                end
                TOUCHING: begin
                    if (!frame_hit) begin
                        if (DEB == 3'd1) begin
                            state_next   = NOT_TOUCHING;
                            release_next = 1'b1;
                        end else begin
                            state_next = RELEASING;
                            dcnt_next  = 3'd1;
                        end
                    end
                end
                RELEASING: begin
                    if (!frame_hit) begin
                        if (dcnt_inc == DEB) begin
                            state_next   = NOT_TOUCHING;
                            dcnt_next    = '0;
                            release_next = 1'b1;
                        end else begin
                            dcnt_next = dcnt_inc;
                        end
                    end else begin
                        state_next = TOUCHING;
                        dcnt_next  = '0;
                    end
                end
                default: begin
                    state_next = NOT_TOUCHING;
                    dcnt_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rope_collision_detector.sv
// tb/tb_rope_collision_detector.sv - randomized self-checking bench for rope_collision_detector
module tb_rope_collision_detector;

    logic clk = 1'b0;
    logic resetN;
    logic startOfFrame, enable, ropeDR, playerDR;

    logic        hit0, touch0, grab0, rel0;
    logic [11:0] ovc0;
    logic        hit1, touch1, grab1, rel1;
    logic [3:0]  ovc1;

    int checks = 0;
    int errors = 0;

    // Reference: per instance, a contact level plus a streak of frames that disagree with it.
    int m_cnt[2], m_seen[2], m_last[2], m_touch[2], m_streak[2];
    int e_hit[2], e_grab[2], e_rel[2];
    int cnt_max[2] = '{4095, 15};
    int deb[2]     = '{2, 1};
    localparam int MIN = 4;

    always #5 clk = ~clk;

    rope_collision_detector dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .ropeDR(ropeDR), .playerDR(playerDR), .hitPulse(hit0), .touching(touch0),
        .grabEvent(grab0), .releaseEvent(rel0), .overlapCount(ovc0)
    );

    rope_collision_detector #(.MIN_OVERLAP_PIXELS(4), .DEBOUNCE_FRAMES(1), .CNT_W(4)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .ropeDR(ropeDR), .playerDR(playerDR), .hitPulse(hit1), .touching(touch1),
        .grabEvent(grab1), .releaseEvent(rel1), .overlapCount(ovc1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_seen[i] = 0; m_last[i] = 0; m_touch[i] = 0; m_streak[i] = 0;
            e_hit[i] = 0; e_grab[i] = 0; e_rel[i] = 0;
        end
    endtask

    task automatic model_step(input bit s, input bit ov);
        for (int i = 0; i < 2; i++) begin
            e_hit[i]  = (ov && (s || m_seen[i] == 0)) ? 1 : 0;
            e_grab[i] = 0;
            e_rel[i]  = 0;
            if (s) begin
                int fh;
                m_last[i] = m_cnt[i];
                fh = (m_cnt[i] >= MIN) ? 1 : 0;
                m_streak[i] = (fh != m_touch[i]) ? m_streak[i] + 1 : 0;
                if (m_streak[i] == deb[i]) begin
                    m_touch[i]  = fh;
                    m_streak[i] = 0;
                    if (fh != 0) e_grab[i] = 1; else e_rel[i] = 1;
                end
                m_cnt[i]  = ov ? 1 : 0;
                m_seen[i] = ov ? 1 : 0;
            end else if (ov) begin
                if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
                m_seen[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("hit0",   int'(hit0),   e_hit[0]);
        check("touch0", int'(touch0), m_touch[0]);
        check("grab0",  int'(grab0),  e_grab[0]);
        check("rel0",   int'(rel0),   e_rel[0]);
        check("ovc0",   int'(ovc0),   m_last[0]);
        check("hit1",   int'(hit1),   e_hit[1]);
        check("touch1", int'(touch1), m_touch[1]);
        check("grab1",  int'(grab1),  e_grab[1]);
        check("rel1",   int'(rel1),   e_rel[1]);
        check("ovc1",   int'(ovc1),   m_last[1]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hit0"}, int'(hit0), 0);   check({tag, "_touch0"}, int'(touch0), 0);
        check({tag, "_grab0"}, int'(grab0), 0); check({tag, "_rel0"}, int'(rel0), 0);
        check({tag, "_ovc0"}, int'(ovc0), 0);   check({tag, "_hit1"}, int'(hit1), 0);
        check({tag, "_touch1"}, int'(touch1), 0); check({tag, "_grab1"}, int'(grab1), 0);
        check({tag, "_rel1"}, int'(rel1), 0);   check({tag, "_ovc1"}, int'(ovc1), 0);
    endtask

    task automatic cycle(input bit s, input bit e, input bit r, input bit p);
        startOfFrame = s; enable = e; ropeDR = r; playerDR = p;
        model_step(s, e & r & p);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // One frame: sof cycle (optionally carrying an overlap pixel), then n_ov overlap
    // pixels starting at offset 3, with non-overlapping rope/player noise elsewhere.
    task automatic frame(input int n_ov, input bit en, input bit coinc, input int len);
        cycle(1'b1, en, coinc, coinc);
        for (int k = 1; k < len; k++) begin
            bit o, r, p;
            o = (k >= 3) && (k < 3 + n_ov);
            r = o || ($urandom_range(0, 2) == 0);
            p = o || (!r && ($urandom_range(0, 2) == 0));
            cycle(1'b0, en, r, p);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; ropeDR = 1'b0; playerDR = 1'b0;
        #2;
        check_all_zero("rst_async");
        model_clear();
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; ropeDR = 1'b0; playerDR = 1'b0;
        model_clear();
        #1;
        do_reset();

        frame(0, 1, 0, 20);
        frame(6, 1, 0, 40);
        frame(6, 1, 0, 40);
        check("arming_ovc", int'(ovc0), 6);
        check("arming_touch", int'(touch0), 0);
        frame(6, 1, 0, 40);
        check("grab_touch", int'(touch0), 1);
        frame(3, 1, 0, 40);
        frame(0, 1, 0, 40);
        frame(0, 1, 0, 40);
        frame(0, 1, 0, 40);
        check("released", int'(touch0), 0);

        frame(6, 1, 0, 40);
        frame(6, 1, 0, 40);
        frame(0, 1, 0, 40);
        frame(10, 1, 0, 40);
        frame(6, 1, 0, 40);
        check("bounce_touch", int'(touch0), 1);

        frame(4, 1, 1, 40);
        frame(0, 1, 0, 40);
        check("coinc_ovc", int'(ovc0), 5);

        frame(20, 1, 0, 40);
        frame(0, 1, 0, 40);
        check("sat_ovc1", int'(ovc1), 15);
        check("sat_ovc0", int'(ovc0), 20);

        frame(50, 0, 0, 60);
        frame(0, 1, 0, 40);
        check("en0_ovc", int'(ovc0), 0);

        frame(6, 1, 0, 40);
        frame(6, 1, 0, 20);
        do_reset();
        frame(6, 1, 0, 40);
        frame(0, 1, 0, 10);
        check("rearm_touch", int'(touch0), 0);

        for (int f = 0; f < 60; f++) begin
            int n;
            n = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 25);
            frame(n, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, 30);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
